// File: rtl/fetch_queue_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode handshake.
// The fetch unit connects as master; memory/decode environment connects as slave.
interface fetch_queue_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_instr;
  logic [ADDR_W-1:0] ir_pc;
  logic [ADDR_W-1:0] ir_pc_next;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output ir_valid, ir_instr, ir_pc, ir_pc_next,
    input  ir_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  ir_valid, ir_instr, ir_pc, ir_pc_next,
    output ir_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Prefetching fetch stage: issues word reads to a 1-cycle synchronous
// instruction memory and buffers {instr, pc} pairs in a DEPTH-entry FIFO
// feeding decode through a valid/ready handshake. Redirect flushes the
// queue and drops any response still in flight.
module fetch_queue_unit #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [ADDR_W-1:0]  PC_STEP   = {{(ADDR_W-1){1'b0}}, 1'b1},
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  fetch_queue_unit_if.master       bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [ADDR_W-1:0] req_pc_r;
  logic              inflight_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] instr_mem_r [DEPTH];
  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];

  logic              ir_valid_s;
  logic              pop_s;
  logic              push_s;
  logic              req_s;
  logic [CNT_W:0]    occupancy_s;
  logic [CNT_W-1:0]  count_next_s;

  // Issue/pop/push decisions; redirect supersedes both pop and push, and
  // requests are held off while in reset or when the slot would overflow.
  always_comb begin
    ir_valid_s   = (count_r != {CNT_W{1'b0}});
    pop_s        = ir_valid_s & bus.ir_ready & ~redirect_valid;
    push_s       = inflight_r & ~redirect_valid;
    occupancy_s  = {1'b0, count_r}
                 + {{CNT_W{1'b0}}, inflight_r}
                 - {{CNT_W{1'b0}}, ir_valid_s & bus.ir_ready};
    req_s        = reset & fetch_en & ~redirect_valid & (occupancy_s < DEPTH_EXT);
    count_next_s = count_r
                 + {{PTR_W{1'b0}}, push_s}
                 - {{PTR_W{1'b0}}, pop_s};
  end

  // PC generation and the single outstanding-request tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_r <= redirect_pc;
      req_pc_r   <= req_pc_r;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= req_s;
      if (req_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
        req_pc_r   <= fetch_pc_r;
      end else begin
        fetch_pc_r <= fetch_pc_r;
        req_pc_r   <= req_pc_r;
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r  <= count_next_s;
    end
  end

  // FIFO storage; contents only matter where count_r marks them occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
      pc_mem_r[wr_ptr_r]    <= req_pc_r;
    end
  end

  // Head presentation and memory request outputs.
  always_comb begin
    bus.imem_req  = req_s;
    bus.imem_addr = fetch_pc_r;
    bus.ir_valid  = ir_valid_s;
    if (ir_valid_s) begin
      bus.ir_instr   = instr_mem_r[rd_ptr_r];
      bus.ir_pc      = pc_mem_r[rd_ptr_r];
      bus.ir_pc_next = pc_mem_r[rd_ptr_r] + PC_STEP;
    end else begin
      bus.ir_instr   = NOP_VALUE;
      bus.ir_pc      = {ADDR_W{1'b0}};
      bus.ir_pc_next = {ADDR_W{1'b0}};
    end
  end

  assign fifo_count = count_r;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, hand-written reset
// sequence, then randomized traffic against an in-order stream model.
module tb_fetch_queue_unit;
  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;
  logic [31:0] salt;
  int          checks;
  int          failures;

  fetch_queue_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  fetch_queue_unit #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fifo_count     (fifo_count),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ salt;
  endfunction

  // Synchronous memory: data one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_data(bus.imem_addr);
    else              bus.imem_rdata <= $urandom;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_cond(input string name, input logic cond, input logic [31:0] act);
    checks++;
    if (cond !== 1'b1) begin
      failures++;
      $display("FAIL %s: condition violated, observed %h at %0t", name, act, $time);
    end
  endtask

  typedef struct {
    logic        fen;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic        ereq;
    logic [31:0] eaddr;
  } vec_t;

  function automatic vec_t v(input logic fen, input logic rv, input logic [31:0] rpc,
                             input logic rdy, input logic ev, input logic [31:0] epc,
                             input logic [2:0] ecnt, input logic ereq, input logic [31:0] eaddr);
    vec_t r;
    r.fen = fen; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
    r.ev = ev; r.epc = epc; r.ecnt = ecnt; r.ereq = ereq; r.eaddr = eaddr;
    return r;
  endfunction

  vec_t tbl [27];

  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic        synced;
  int          delivered;

  initial begin
    checks = 0; failures = 0; salt = 32'h0000_0000;
    reset = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    bus.ir_ready = 1'b1;

    // stream after reset, memory[k]=k
    tbl[0] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h0);
    tbl[1] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h1);
    for (int k = 2; k < 6; k++)
      tbl[k] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'(k - 2), 3'd1, 1'b1, 32'(k));
    // backpressure until full, then release
    tbl[6]  = v(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 3'd1, 1'b1, 32'h6);
    tbl[7]  = v(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 3'd2, 1'b1, 32'h7);
    tbl[8]  = v(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 3'd3, 1'b0, 32'h0);
    tbl[9]  = v(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 3'd4, 1'b0, 32'h0);
    tbl[10] = v(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 3'd4, 1'b0, 32'h0);
    tbl[11] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 3'd4, 1'b1, 32'h8);
    tbl[12] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h5, 3'd3, 1'b1, 32'h9);
    tbl[13] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6, 3'd3, 1'b1, 32'hA);
    // redirect with 3 buffered + 1 in flight
    tbl[14] = v(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, 32'h7, 3'd3, 1'b0, 32'h0);
    tbl[15] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h40);
    tbl[16] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h41);
    tbl[17] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 3'd1, 1'b1, 32'h42);
    // redirect coinciding with a pop, target near the wrap point
    tbl[18] = v(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'h41, 3'd1, 1'b0, 32'h0);
    tbl[19] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'hFFFF_FFFE);
    tbl[20] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'hFFFF_FFFF);
    tbl[21] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFE, 3'd1, 1'b1, 32'h0);
    tbl[22] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 3'd1, 1'b1, 32'h1);
    tbl[23] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 3'd1, 1'b1, 32'h2);
    // redirect while fetch disabled
    tbl[24] = v(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h1, 3'd1, 1'b0, 32'h0);
    tbl[25] = v(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    tbl[26] = v(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 3'd0, 1'b1, 32'h100);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", {31'b0, bus.ir_valid}, 32'h0);
    chk("rst_count", {29'b0, fifo_count}, 32'h0);
    chk("rst_instr", bus.ir_instr, 32'h0);
    chk("rst_pc", bus.ir_pc, 32'h0);
    chk("rst_pc_next", bus.ir_pc_next, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);

    // table-driven directed vectors
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      reset = 1'b1;
      fetch_en = tbl[i].fen; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; bus.ir_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus.ir_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("tbl%0d_count", i), {29'b0, fifo_count}, {29'b0, tbl[i].ecnt});
      chk($sformatf("tbl%0d_req", i), {31'b0, bus.imem_req}, {31'b0, tbl[i].ereq});
      if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), bus.ir_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), bus.ir_instr, mem_data(tbl[i].epc));
        chk($sformatf("tbl%0d_pc_next", i), bus.ir_pc_next, tbl[i].epc + 32'h1);
      end else begin
        chk($sformatf("tbl%0d_nop", i), bus.ir_instr, 32'h0);
      end
    end

    // async reset with 3 entries buffered
    redirect_valid = 1'b0; fetch_en = 1'b1;
    @(negedge clk); bus.ir_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); #1;
    chk("arst_pre_count", {29'b0, fifo_count}, 32'h3);
    #1 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, bus.ir_valid}, 32'h0);
    chk("arst_count", {29'b0, fifo_count}, 32'h0);
    chk("arst_instr", bus.ir_instr, 32'h0);
    chk("arst_req", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    reset = 1'b1; bus.ir_ready = 1'b1;
    #1;
    chk("arst_first_req", {31'b0, bus.imem_req}, 32'h1);
    chk("arst_first_addr", bus.imem_addr, 32'h0);

    // randomized traffic against an in-order stream model
    salt = 32'hC0DE_5A5A;
    synced = 1'b0; delivered = 0; exp_pc = 32'h0; exp_req = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      fetch_en       = ($urandom_range(0, 9) != 0);
      bus.ir_ready   = ($urandom_range(0, 3) != 0);
      redirect_valid = (c == 0) || ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 1) != 0) ? 32'($urandom)
                                                   : (32'hFFFF_FFFC + 32'($urandom_range(0, 3)));
      #1;
      if (synced) begin
        if (bus.ir_valid) begin
          chk("rnd_pc", bus.ir_pc, exp_pc);
          chk("rnd_instr", bus.ir_instr, mem_data(exp_pc));
          chk("rnd_pc_next", bus.ir_pc_next, exp_pc + 32'h1);
        end else begin
          chk("rnd_nop", bus.ir_instr, 32'h0);
        end
        if (bus.imem_req) chk("rnd_addr", bus.imem_addr, exp_req);
      end
      if (redirect_valid || !fetch_en) chk("rnd_req_blocked", {31'b0, bus.imem_req}, 32'h0);
      chk_cond("rnd_count_bound", fifo_count <= 3'd4, {29'b0, fifo_count});
      chk_cond("rnd_valid_vs_count", bus.ir_valid == (fifo_count != 3'd0), {29'b0, fifo_count});
      if (fifo_count == 3'd4 && !bus.ir_ready)
        chk("rnd_full_no_req", {31'b0, bus.imem_req}, 32'h0);
      if (redirect_valid) begin
        exp_pc = redirect_pc; exp_req = redirect_pc; synced = 1'b1;
      end else begin
        if (bus.ir_valid && bus.ir_ready) begin
          exp_pc = exp_pc + 32'h1; delivered++;
        end
        if (bus.imem_req) exp_req = exp_req + 32'h1;
      end
    end
    chk_cond("rnd_progress", delivered > 500, 32'(delivered));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised successor to the single-register fetch stage: generates the PC, issues word reads to a 1-cycle-latency synchronous instruction memory, and buffers returned words with their PCs in a DEPTH-entry prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake, with stall via backpressure, branch redirect with flush, and NOP fill when empty.
- Sits between instruction memory and the IR2/PC2 decode pipeline registers.

Parameters:
- DATA_W, 32, instruction width.
- ADDR_W, 32, PC width (word addressed).
- DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 0, PC loaded on reset.
- PC_STEP, 1, PC increment per sequential fetch.
- NOP_VALUE, 0, value driven on ir_instr when ir_valid=0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new memory requests; 0 freezes the PC and requests, while the FIFO still drains.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_W  read address; valid when imem_req=1.
- imem_rdata  in  DATA_W  read data; valid exactly one cycle after the cycle with imem_req=1.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  ADDR_W  redirect target.
- ir_valid  out  1  head instruction available.
- ir_ready  in  1  decode accepts the head.
- ir_instr  out  DATA_W  head instruction, or NOP_VALUE when ir_valid=0.
- ir_pc  out  ADDR_W  PC of the head instruction.
- ir_pc_next  out  ADDR_W  ir_pc+PC_STEP, mod 2^ADDR_W.
- fifo_count  out  clog2(DEPTH)+1  occupied entries.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - Internal state: fetch_pc=RESET_PC, FIFO empty, in-flight flag=0.
  - Outputs: imem_req=0, ir_valid=0, ir_instr=NOP_VALUE, ir_pc=0, ir_pc_next=0, fifo_count=0.
  - Reset asserted mid-operation discards all buffered and in-flight data immediately.
- **Issue:**
  - imem_req = fetch_en & ~redirect_valid & (fifo_count - pop + inflight < DEPTH), where pop = ir_valid & ir_ready and inflight = request issued last cycle and not squashed.
  - imem_addr = fetch_pc.
  - On issue, fetch_pc += PC_STEP and wraps mod 2^ADDR_W (0xFFFFFFFF -> 0 at ADDR_W=32).
- **Response:** when the in-flight flag is set, {imem_rdata, request addr} is written at the next edge to FIFO tail.
- **Latency and throughput:**
  - Request in cycle N -> ir_valid in cycle N+2 when the FIFO was empty.
  - Sustains 1 instr/cycle with ir_ready held high, for any DEPTH>=2.
- **Output:**
  - ir_valid = FIFO non-empty.
  - ir_instr, ir_pc, ir_pc_next come from the head combinationally.
  - The head pops on the edge where ir_valid & ir_ready.
  - The head is held stable while ir_valid & ~ir_ready.
- **Full:** when fifo_count + inflight = DEPTH and no pop, no request is issued. No entry is ever dropped or overwritten.
- **Empty:** ir_valid=0, ir_instr=NOP_VALUE. ir_ready is ignored.
- **Redirect (sampled at edge):**
  - FIFO flushed to empty.
  - In-flight flag cleared; the response arriving next cycle is discarded.
  - fetch_pc = redirect_pc.
  - No request in the redirect cycle; the first request at redirect_pc is in cycle R+1, giving ir_valid in R+3.
- **Simultaneous events:**
  - Redirect with ir_valid & ir_ready: the pop is superseded; the head counts as flushed.
  - Redirect with fetch_en=0: PC still loads, and no request is issued until fetch_en=1.
  - Push and pop in the same cycle: count unchanged.
- **Ordering:** responses enter the FIFO in request order; at most one request is in flight.
- **Pointers:** FIFO read/write pointers are clog2(DEPTH) bits and wrap naturally; fifo_count is tracked separately and never exceeds DEPTH.

Test Plan:
- **Reset then stream:** memory[k]=k for k=0..15, fetch_en=1, ir_ready=1 -> first ir_valid 2 cycles after the first imem_req; consumed (ir_pc, ir_instr) = (0,0), (1,1), (2,2)... one per cycle; ir_pc_next=ir_pc+1.
- **Backpressure/full:** DEPTH=4, ir_ready=0 for 10 cycles -> fifo_count saturates at 4, imem_req=0 while full, head holds (0,0). Release -> values 0..9 emerge in order, none lost or duplicated.
- **Redirect flush:** redirect_valid=1, redirect_pc=0x40 while FIFO holds 3 entries and 1 request is in flight -> fifo_count=0 next cycle, stale response dropped, next delivered ir_pc=0x40 with ir_instr=memory[0x40], 3 cycles after the redirect.
- **Redirect with pop:** redirect and ir_valid&ir_ready in the same cycle -> the head is not delivered again, and the next delivered ir_pc is redirect_pc.
- **Wrap:** redirect_pc=0xFFFFFFFE -> delivered ir_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, with ir_pc_next=0x0 for the 0xFFFFFFFF entry.
- **Async reset mid-stream:** reset=0 between clock edges with 3 entries buffered -> ir_valid=0, fifo_count=0, ir_instr=NOP_VALUE immediately. After release, the first imem_addr=RESET_PC.
